ipsxe_floating_point_one_dec_shl8_v1_0: RTL and testbench

- Inverse of the 8-bit leading-one locator used in fixed-to-float (fx2fl) normalisation.
- Takes a 3-bit leading-one location and a 7-bit fraction (implicit leading one). Rebuilds the 8-bit fixed-point magnitude with the one placed at bit `loc`.
- Used on the float-to-fixed (fl2fx) denormalisation path.
- 2-stage pipelined right barrel shifter with valid tracking, zero forcing and an inexact flag.

---
 rtl/ipsxe_floating_point_one_dec_shl8_v1_0_pkg.sv | 22 ++
 rtl/ipsxe_floating_point_shr_stage_v1_0.sv | 27 ++
 rtl/ipsxe_floating_point_one_dec_shl8_v1_0.sv | 143 ++++++++++++++
 tb/tb_ipsxe_floating_point_one_dec_shl8_v1_0.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_one_dec_shl8_v1_0_pkg.sv
// Shared constants and stage-1 bundle for the 8-bit leading-one decoder/shifter.
// The guard field exists only when IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN is defined.
package ipsxe_floating_point_one_dec_shl8_v1_0_pkg;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned LOC_W        = 3;
    localparam int unsigned FRAC_W       = 7;
    localparam int unsigned COARSE_SHIFT = 4;

    typedef struct packed {
        logic             valid;
        logic             zero;
        logic             sticky;
`ifdef IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN
        // Highest bit lost in stage 1, needed separately for round-to-nearest-even
        logic             guard;
`endif
        logic [WIDTH-1:0] data;
        logic [1:0]       s_lo;
    } stage1_t;

endpackage

// File: rtl/ipsxe_floating_point_shr_stage_v1_0.sv
// Conditional right shift by a constant amount, reporting the highest lost bit
// and the OR of the remaining lost bits.
module ipsxe_floating_point_shr_stage_v1_0 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] shifted,
    output logic             lost_msb,
    output logic             lost_rest
);

    always_comb begin
        shifted   = data;
        lost_msb  = 1'b0;
        lost_rest = 1'b0;
        if (en) begin
            shifted  = data >> SHIFT;
            lost_msb = data[SHIFT-1];
            for (int i = 0; i < int'(SHIFT) - 1; i++) begin
                lost_rest = lost_rest | data[i];
            end
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_one_dec_shl8_v1_0.sv
// Rebuilds an 8-bit magnitude from a leading-one location and fraction via a 2-stage
// right barrel shifter. Define IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN for RNE rounding.
module ipsxe_floating_point_one_dec_shl8_v1_0
    import ipsxe_floating_point_one_dec_shl8_v1_0_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_aclken,
    input  logic              i_valid,
    input  logic [LOC_W-1:0]  i_loc,
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_zero,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_valid,
    output logic              o_zero,
    output logic              o_inexact
);

    logic [LOC_W-1:0] s;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] coarse;
    logic             c_msb;
    logic             c_rest;
    stage1_t          s1_d;
    stage1_t          s1_q;

    // s = 7 - loc; the leading one lands at bit loc after shifting right by s
    assign s = LOC_W'(FRAC_W) - i_loc;
    assign m = {1'b1, i_frac};

    ipsxe_floating_point_shr_stage_v1_0 #(
        .WIDTH (WIDTH),
        .SHIFT (COARSE_SHIFT)
    ) u_shr_coarse (
        .en        (s[LOC_W-1]),
        .data      (m),
        .shifted   (coarse),
        .lost_msb  (c_msb),
        .lost_rest (c_rest)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = i_valid;
        s1_d.zero  = i_zero;
        s1_d.s_lo  = s[1:0];
        if (!i_zero) begin
            s1_d.data = coarse;
`ifdef IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN
            s1_d.guard  = c_msb;
            s1_d.sticky = c_rest;
`else
            s1_d.sticky = c_msb | c_rest;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q <= '0;
        end else if (i_aclken) begin
            s1_q <= s1_d;
        end
    end

    logic [WIDTH-1:0] sh2;
    logic [WIDTH-1:0] sh1;
    logic             m2;
    logic             r2;
    logic             m1;
    logic             r1;
    logic [WIDTH-1:0] data_d;
    logic             inexact_d;

    ipsxe_floating_point_shr_stage_v1_0 #(
        .WIDTH (WIDTH),
        .SHIFT (2)
    ) u_shr_mid (
        .en        (s1_q.s_lo[1]),
        .data      (s1_q.data),
        .shifted   (sh2),
        .lost_msb  (m2),
        .lost_rest (r2)
    );

    ipsxe_floating_point_shr_stage_v1_0 #(
        .WIDTH (WIDTH),
        .SHIFT (1)
    ) u_shr_fine (
        .en        (s1_q.s_lo[0]),
        .data      (sh2),
        .shifted   (sh1),
        .lost_msb  (m1),
        .lost_rest (r1)
    );

`ifdef IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN
    logic g_a;
    logic st_a;
    logic g_b;
    logic st_b;
    logic round_up;

    // Each enabled shift demotes the previous guard into the sticky OR
    always_comb begin
        g_a  = s1_q.guard;
        st_a = s1_q.sticky;
        if (s1_q.s_lo[1]) begin
            st_a = st_a | g_a | r2;
            g_a  = m2;
        end
        g_b  = g_a;
        st_b = st_a;
        if (s1_q.s_lo[0]) begin
            st_b = st_b | g_b | r1;
            g_b  = m1;
        end
        round_up  = g_b & (st_b | sh1[0]);
        data_d    = sh1 + WIDTH'(round_up);
        inexact_d = g_b | st_b;
    end
`else
    always_comb begin
        data_d    = sh1;
        inexact_d = s1_q.sticky | m2 | r2 | m1 | r1;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_zero    <= 1'b0;
            o_inexact <= 1'b0;
        end else if (i_aclken) begin
            o_data    <= data_d;
            o_valid   <= s1_q.valid;
            o_zero    <= s1_q.zero;
            o_inexact <= inexact_d;
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_one_dec_shl8_v1_0.sv
// Self-checking bench: directed vectors plus randomized traffic against an
// arithmetic reference model with a 2-deep latency queue.
module tb_ipsxe_floating_point_one_dec_shl8_v1_0;

    typedef struct packed {
        logic       valid;
        logic       zero;
        logic [7:0] data;
        logic       inexact;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       aclken;
    logic       valid;
    logic [2:0] loc;
    logic [6:0] frac;
    logic       zero;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_zero;
    logic       o_inexact;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t mid_e = '0;
    exp_t out_e = '0;

    always #5 clk = ~clk;

    ipsxe_floating_point_one_dec_shl8_v1_0 dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_aclken  (aclken),
        .i_valid   (valid),
        .i_loc     (loc),
        .i_frac    (frac),
        .i_zero    (zero),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_zero    (o_zero),
        .o_inexact (o_inexact)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value semantics: m = 1.frac scaled so the leading one sits at bit loc
    function automatic exp_t ref_calc(input logic v, input int l, input int f, input logic z);
        exp_t e;
        int   mm, sh, d, rem, half;
        e       = '0;
        e.valid = v;
        if (z) begin
            e.zero = 1'b1;
            return e;
        end
        mm  = 128 + f;
        sh  = 7 - l;
        d   = mm / (1 << sh);
        rem = mm % (1 << sh);
        e.inexact = (rem != 0);
`ifdef IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN
        if (sh > 0) begin
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (d % 2) == 1)) d = d + 1;
        end
`else
        half = 0;
`endif
        e.data = 8'(d);
        return e;
    endfunction

    task automatic cycle(input logic r, input logic en, input logic v, input logic [2:0] l,
                         input logic [6:0] f, input logic z);
        rst_n  = r;
        aclken = en;
        valid  = v;
        loc    = l;
        frac   = f;
        zero   = z;
        @(posedge clk);
        if (!r) begin
            out_e = '0;
            mid_e = '0;
        end else if (en) begin
            out_e = mid_e;
            mid_e = ref_calc(v, int'(l), int'(f), z);
        end
        #1;
        check("valid", 32'(o_valid), 32'(out_e.valid));
        check("zero", 32'(o_zero), 32'(out_e.zero));
        check("data", 32'(o_data), 32'(out_e.data));
        check("inexact", 32'(o_inexact), 32'(out_e.inexact));
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input logic [2:0] l, input logic [6:0] f,
                           input logic [7:0] ed, input logic ei);
        cycle(1'b1, 1'b1, 1'b1, l, f, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_data"}, 32'(o_data), 32'(ed));
        check({tag, "_inexact"}, 32'(o_inexact), 32'(ei));
        check({tag, "_zero"}, 32'(o_zero), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; aclken = 1'b1; valid = 1'b0; loc = '0; frac = '0; zero = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'($urandom), 7'($urandom), 1'($urandom));
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_data", 32'(o_data), 32'd0);
            check("rst_inexact", 32'(o_inexact), 32'd0);
        end

        // First sample after release: visible two enabled cycles later
        cycle(1'b1, 1'b1, 1'b1, 3'd3, 7'b0110000, 1'b0);
        check("lat1_valid", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0);
        check("lat2_valid", 32'(o_valid), 32'd1);
        check("loc3_data", 32'(o_data), 32'h0B);
        check("loc3_inexact", 32'(o_inexact), 32'd0);
        check("loc3_zero", 32'(o_zero), 32'd0);

        run_vec("loc7", 3'd7, 7'h7F, 8'hFF, 1'b0);
`ifdef IPSXE_FLOATING_POINT_ONE_DEC_ROUND_EN
        run_vec("loc0", 3'd0, 7'h40, 8'h02, 1'b1);
`else
        run_vec("loc0", 3'd0, 7'h40, 8'h01, 1'b1);
`endif
        run_vec("loc2", 3'd2, 7'b0101000, 8'h05, 1'b1);

        // Stream with enable gap and a zero sample
        cycle(1'b1, 1'b1, 1'b1, 3'd5, 7'h15, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 3'd1, 7'h33, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 3'($urandom), 7'($urandom), 1'b0);
        check("hold1_valid", 32'(o_valid), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 3'($urandom), 7'($urandom), 1'b1);
        check("hold2_valid", 32'(o_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 3'd4, 7'h7F, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'd6, 7'h01, 1'b0);
        check("zs_zero", 32'(o_zero), 32'd1);
        check("zs_data", 32'(o_data), 32'd0);
        check("zs_inexact", 32'(o_inexact), 32'd0);
        check("zs_valid", 32'(o_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0), 3'($urandom), 7'($urandom),
                  ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
